// File: rtl/core_regfile_sb.sv
// core_regfile_sb: integer + FP register files with a per-register
// pending-write scoreboard, two registered read ports per file and the PC.
// Optional build macro: CORE_REGFILE_BYPASS_EN (same-edge write-to-read bypass).
module core_regfile_sb #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // full-word write port
  input  logic                     we_i,
  input  logic                     wsel_i,
  input  logic [$clog2(NREG)-1:0]  waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  // byte input write (integer file only)
  input  logic                     ine_i,
  input  logic [7:0]               indata_i,
  // scoreboard set port
  input  logic                     busy_set_i,
  input  logic                     busy_sel_i,
  input  logic [$clog2(NREG)-1:0]  busy_addr_i,
  // read ports
  input  logic                     re_i,
  input  logic [$clog2(NREG)-1:0]  rs1addr_i,
  input  logic [$clog2(NREG)-1:0]  rs2addr_i,
  input  logic [$clog2(NREG)-1:0]  frs1addr_i,
  input  logic [$clog2(NREG)-1:0]  frs2addr_i,
  output logic [XLEN-1:0]          rs1_o,
  output logic [XLEN-1:0]          rs2_o,
  output logic [XLEN-1:0]          frs1_o,
  output logic [XLEN-1:0]          frs2_o,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  output logic                     frs1_busy_o,
  output logic                     frs2_busy_o,
  // program counter
  input  logic                     pc_we_i,
  input  logic [XLEN-1:0]          pc_wdata_i,
  output logic [XLEN-1:0]          pc_o
);

  localparam int unsigned AW = $clog2(NREG);

  // Replace the low byte of a word, keeping the upper bits.
  function automatic logic [XLEN-1:0] merge_byte(input logic [XLEN-1:0] word,
                                                 input logic [7:0]      b);
    logic [XLEN-1:0] r;
    r      = word;
    r[7:0] = b;
    return r;
  endfunction

  logic [XLEN-1:0] int_q [NREG];
  logic [XLEN-1:0] int_d [NREG];
  logic [XLEN-1:0] fp_q  [NREG];
  logic [XLEN-1:0] fp_d  [NREG];
  logic [NREG-1:0] int_busy_q, int_busy_d;
  logic [NREG-1:0] fp_busy_q,  fp_busy_d;

  logic [XLEN-1:0] int_src_s [NREG];
  logic [XLEN-1:0] fp_src_s  [NREG];
  logic [NREG-1:0] int_bsrc_s, fp_bsrc_s;

  logic [XLEN-1:0] rs1_q, rs2_q, frs1_q, frs2_q;
  logic [XLEN-1:0] rs1_d, rs2_d, frs1_d, frs2_d;
  logic            rs1_busy_q, rs2_busy_q, frs1_busy_q, frs2_busy_q;
  logic            rs1_busy_d, rs2_busy_d, frs1_busy_d, frs2_busy_d;
  logic [XLEN-1:0] pc_q;

  // Next state of both files and scoreboards; byte input beats full-word write,
  // and a new busy set beats the clear from a committing write.
  always_comb begin
    logic int_ine_hit, int_we_hit, int_set, fp_we_hit, fp_set;
    int_d      = int_q;
    fp_d       = fp_q;
    int_busy_d = int_busy_q;
    fp_busy_d  = fp_busy_q;
    for (int i = 0; i < int'(NREG); i++) begin
      int_ine_hit = ine_i && (waddr_i == AW'(i));
      int_we_hit  = we_i && !wsel_i && (waddr_i == AW'(i));
      int_set     = busy_set_i && !busy_sel_i && (busy_addr_i == AW'(i));
      fp_we_hit   = we_i && wsel_i && (waddr_i == AW'(i));
      fp_set      = busy_set_i && busy_sel_i && (busy_addr_i == AW'(i));

      if (i == 0) begin
        int_d[i]      = '0;
        int_busy_d[i] = 1'b0;
      end else if (int_ine_hit) begin
        int_d[i]      = merge_byte(int_q[i], indata_i);
        int_busy_d[i] = 1'b1;
        int_busy_d[i] = int_set;
      end else if (int_we_hit) begin
        int_d[i]      = wdata_i;
        int_busy_d[i] = int_set;
      end else begin
        int_d[i]      = int_q[i];
        int_busy_d[i] = int_set | int_busy_q[i];
      end

      if (fp_we_hit) begin
        fp_d[i]      = wdata_i;
        fp_busy_d[i] = fp_set;
      end else begin
        fp_d[i]      = fp_q[i];
        fp_busy_d[i] = fp_set | fp_busy_q[i];
      end
    end
  end

  // Select what a read at this edge observes: committed state or post-edge state.
  always_comb begin
`ifdef CORE_REGFILE_BYPASS_EN
    int_src_s  = int_d;
    fp_src_s   = fp_d;
    int_bsrc_s = int_busy_d;
    fp_bsrc_s  = fp_busy_d;
`else
    int_src_s  = int_q;
    fp_src_s   = fp_q;
    int_bsrc_s = int_busy_q;
    fp_bsrc_s  = fp_busy_q;
`endif
  end

  // Read-port next values; integer x0 is forced to zero and never busy.
  always_comb begin
    if (rs1addr_i == '0) begin
      rs1_d      = '0;
      rs1_busy_d = 1'b0;
    end else begin
      rs1_d      = int_src_s[rs1addr_i];
      rs1_busy_d = int_bsrc_s[rs1addr_i];
    end
    if (rs2addr_i == '0) begin
      rs2_d      = '0;
      rs2_busy_d = 1'b0;
    end else begin
      rs2_d      = int_src_s[rs2addr_i];
      rs2_busy_d = int_bsrc_s[rs2addr_i];
    end
    frs1_d      = fp_src_s[frs1addr_i];
    frs1_busy_d = fp_bsrc_s[frs1addr_i];
    frs2_d      = fp_src_s[frs2addr_i];
    frs2_busy_d = fp_bsrc_s[frs2addr_i];
  end

  // Register files and scoreboards; reset clears everything, dropping any same-edge update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        int_q[i] <= '0;
        fp_q[i]  <= '0;
      end
      int_busy_q <= '0;
      fp_busy_q  <= '0;
    end else begin
      int_q      <= int_d;
      fp_q       <= fp_d;
      int_busy_q <= int_busy_d;
      fp_busy_q  <= fp_busy_d;
    end
  end

  // Registered read outputs; RE low holds all eight outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      frs1_q      <= '0;
      frs2_q      <= '0;
      rs1_busy_q  <= 1'b0;
      rs2_busy_q  <= 1'b0;
      frs1_busy_q <= 1'b0;
      frs2_busy_q <= 1'b0;
    end else if (re_i) begin
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      frs1_q      <= frs1_d;
      frs2_q      <= frs2_d;
      rs1_busy_q  <= rs1_busy_d;
      rs2_busy_q  <= rs2_busy_d;
      frs1_busy_q <= frs1_busy_d;
      frs2_busy_q <= frs2_busy_d;
    end else begin
      rs1_q       <= rs1_q;
      rs2_q       <= rs2_q;
      frs1_q      <= frs1_q;
      frs2_q      <= frs2_q;
      rs1_busy_q  <= rs1_busy_q;
      rs2_busy_q  <= rs2_busy_q;
      frs1_busy_q <= frs1_busy_q;
      frs2_busy_q <= frs2_busy_q;
    end
  end

  // Program counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else if (pc_we_i) begin
      pc_q <= pc_wdata_i;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
  assign frs1_o      = frs1_q;
  assign frs2_o      = frs2_q;
  assign rs1_busy_o  = rs1_busy_q;
  assign rs2_busy_o  = rs2_busy_q;
  assign frs1_busy_o = frs1_busy_q;
  assign frs2_busy_o = frs2_busy_q;
  assign pc_o        = pc_q;

endmodule

// File: tb/tb_core_regfile_sb.sv
// Directed bench for core_regfile_sb: read expectations are queued when a read
// is issued and compared one edge later when the registered outputs appear.
module tb_core_regfile_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic            clk, rst_n;
  logic            we, wsel, ine, busy_set, busy_sel, re, pc_we;
  logic [AW-1:0]   waddr, busy_addr, rs1a, rs2a, frs1a, frs2a;
  logic [XLEN-1:0] wdata, pc_wdata;
  logic [7:0]      indata;
  logic [XLEN-1:0] rs1, rs2, frs1, frs2, pc;
  logic            rs1_b, rs2_b, frs1_b, frs2_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [3:0]  dmask;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  bmask;
    logic [3:0]  b;
  } exp_t;

  exp_t exp_q[$];

  core_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .RESET_PC(32'h0000_0100)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .we_i(we), .wsel_i(wsel), .waddr_i(waddr), .wdata_i(wdata),
    .ine_i(ine), .indata_i(indata),
    .busy_set_i(busy_set), .busy_sel_i(busy_sel), .busy_addr_i(busy_addr),
    .re_i(re), .rs1addr_i(rs1a), .rs2addr_i(rs2a), .frs1addr_i(frs1a), .frs2addr_i(frs2a),
    .rs1_o(rs1), .rs2_o(rs2), .frs1_o(frs1), .frs2_o(frs2),
    .rs1_busy_o(rs1_b), .rs2_busy_o(rs2_b), .frs1_busy_o(frs1_b), .frs2_busy_o(frs2_b),
    .pc_we_i(pc_we), .pc_wdata_i(pc_wdata), .pc_o(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [3:0] dm,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [3:0] bm, input logic [3:0] b);
    exp_t e;
    e.tag = tag; e.dmask = dm; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3;
    e.bmask = bm; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [31:0] od [4];
    logic [31:0] ed [4];
    logic [3:0]  ob;
    e = exp_q.pop_front();
    od[0] = rs1; od[1] = rs2; od[2] = frs1; od[3] = frs2;
    ed[0] = e.d0; ed[1] = e.d1; ed[2] = e.d2; ed[3] = e.d3;
    ob = {frs2_b, frs1_b, rs2_b, rs1_b};
    for (int k = 0; k < 4; k++) begin
      if (e.dmask[k]) begin
        checks++;
        assert (od[k] === ed[k]) else begin
          errors++;
          $error("FAIL %s data[%0d] observed=%h expected=%h", e.tag, k, od[k], ed[k]);
        end
      end
      if (e.bmask[k]) begin
        checks++;
        assert (ob[k] === e.b[k]) else begin
          errors++;
          $error("FAIL %s busy[%0d] observed=%b expected=%b", e.tag, k, ob[k], e.b[k]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check_pop();
  endtask

  task automatic idle();
    we = 1'b0; ine = 1'b0; busy_set = 1'b0; pc_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wsel = 1'b0; ine = 1'b0; busy_set = 1'b0; busy_sel = 1'b0;
    re = 1'b0; pc_we = 1'b0; waddr = '0; busy_addr = '0; rs1a = '0; rs2a = '0;
    frs1a = '0; frs2a = '0; wdata = '0; pc_wdata = '0; indata = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0000_0100);
    chk("rst_rs1", rs1, 32'h0);
    chk("rst_rs2", rs2, 32'h0);
    chk("rst_frs1", frs1, 32'h0);
    chk("rst_frs2", frs2, 32'h0);
    chk("rst_busy", {28'h0, frs2_b, frs1_b, rs2_b, rs1_b}, 32'h0);
    rst_n = 1'b1;
    re = 1'b1;

    // plain integer write then read
    we = 1'b1; wsel = 1'b0; waddr = 5'd5; wdata = 32'hDEAD_BEEF; tick(); idle();
    rs1a = 5'd5;
    expect_rd("wr_x5", 4'b0001, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000); tick();

    // write to x0 is discarded
    we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; tick(); idle();
    rs2a = 5'd0;
    expect_rd("wr_x0", 4'b0010, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0010, 4'b0000); tick();

    // f0 is a real register
    we = 1'b1; wsel = 1'b1; waddr = 5'd0; wdata = 32'h3F80_0000; tick(); idle(); wsel = 1'b0;
    frs1a = 5'd0;
    expect_rd("wr_f0", 4'b0100, 32'h0, 32'h0, 32'h3F80_0000, 32'h0, 4'b0000, 4'b0000); tick();

    // byte input merge beats a same-cycle full write
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; tick(); idle();
    ine = 1'b1; indata = 8'hAB; we = 1'b1; wdata = 32'hFFFF_FFFF; waddr = 5'd7; tick(); idle();
    rs1a = 5'd7;
    expect_rd("ine_x7", 4'b0001, 32'h1234_56AB, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000); tick();

    // byte input to x0 has no effect
    ine = 1'b1; indata = 8'hCC; waddr = 5'd0; tick(); idle();
    rs2a = 5'd0;
    expect_rd("ine_x0", 4'b0010, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000); tick();

    // byte input ignores WSEL: lands in x8, f8 untouched
    ine = 1'b1; wsel = 1'b1; indata = 8'h5A; waddr = 5'd8; tick(); idle(); wsel = 1'b0;
    rs1a = 5'd8; frs2a = 5'd8;
    expect_rd("ine_wsel", 4'b1001, 32'h0000_005A, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000); tick();

    // scoreboard set, clear, set-wins, x0 never busy
    busy_set = 1'b1; busy_sel = 1'b0; busy_addr = 5'd3; tick(); idle();
    rs1a = 5'd3;
    expect_rd("busy_x3", 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0001); tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033; tick(); idle();
    expect_rd("clr_x3", 4'b0001, 32'h0000_0033, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000); tick();
    busy_set = 1'b1; busy_addr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0044; tick(); idle();
    expect_rd("setwins_x3", 4'b0001, 32'h0000_0044, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0001); tick();
    busy_set = 1'b1; busy_addr = 5'd0; tick(); idle();
    rs2a = 5'd0;
    expect_rd("busy_x0", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0010, 4'b0000); tick();

    // FP scoreboard
    busy_set = 1'b1; busy_sel = 1'b1; busy_addr = 5'd2; tick(); idle(); busy_sel = 1'b0;
    frs2a = 5'd2;
    expect_rd("busy_f2", 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1000, 4'b1000); tick();
    we = 1'b1; wsel = 1'b1; waddr = 5'd2; wdata = 32'h0000_00F2; tick(); idle(); wsel = 1'b0;
    expect_rd("clr_f2", 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0000_00F2, 4'b1000, 4'b0000); tick();

    // read hold while addresses and contents change
    rs1a = 5'd5; rs2a = 5'd3; frs1a = 5'd0; frs2a = 5'd2;
    expect_rd("hold_pre", 4'b1111, 32'hDEAD_BEEF, 32'h0000_0044, 32'h3F80_0000, 32'h0000_00F2,
              4'b1111, 4'b0010); tick();
    re = 1'b0; rs1a = 5'd7; rs2a = 5'd0; frs1a = 5'd2; frs2a = 5'd0;
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_5555;
    expect_rd("hold1", 4'b1111, 32'hDEAD_BEEF, 32'h0000_0044, 32'h3F80_0000, 32'h0000_00F2,
              4'b1111, 4'b0010); tick(); idle();
    we = 1'b1; wsel = 1'b1; waddr = 5'd0; wdata = 32'h1111_1111;
    expect_rd("hold2", 4'b1111, 32'hDEAD_BEEF, 32'h0000_0044, 32'h3F80_0000, 32'h0000_00F2,
              4'b1111, 4'b0010); tick(); idle(); wsel = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0066;
    expect_rd("hold3", 4'b1111, 32'hDEAD_BEEF, 32'h0000_0044, 32'h3F80_0000, 32'h0000_00F2,
              4'b1111, 4'b0010); tick(); idle();
    re = 1'b1; rs1a = 5'd5; rs2a = 5'd3; frs1a = 5'd0; frs2a = 5'd2;
    expect_rd("hold_rel", 4'b1111, 32'h0000_5555, 32'h0000_0066, 32'h1111_1111, 32'h0000_00F2,
              4'b1111, 4'b0000); tick();

    // same-edge write and read of x9
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099; tick(); idle();
    rs2a = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
`ifdef CORE_REGFILE_BYPASS_EN
    expect_rd("same_edge", 4'b0010, 32'h0, 32'h0000_0055, 32'h0, 32'h0, 4'b0000, 4'b0000); tick(); idle();
`else
    expect_rd("same_edge", 4'b0010, 32'h0, 32'h0000_0099, 32'h0, 32'h0, 4'b0000, 4'b0000); tick(); idle();
`endif
    expect_rd("after_edge", 4'b0010, 32'h0, 32'h0000_0055, 32'h0, 32'h0, 4'b0000, 4'b0000); tick();

    // PC write and hold
    pc_we = 1'b1; pc_wdata = 32'h0000_2000; tick(); idle();
    chk("pc_wr", pc, 32'h0000_2000);
    pc_wdata = 32'h0000_0003; tick();
    chk("pc_hold", pc, 32'h0000_2000);

    // asynchronous reset in the middle of a write
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_AAAA; pc_we = 1'b1; pc_wdata = 32'h0000_4000;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rs1", rs1, 32'h0);
    chk("arst_rs2", rs2, 32'h0);
    chk("arst_frs1", frs1, 32'h0);
    chk("arst_pc", pc, 32'h0000_0100);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    rs1a = 5'd5; re = 1'b1;
    expect_rd("lost_wr", 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000); tick();
    chk("arst_pc_after", pc, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
